// File: rtl/avg_sub_calc_pkg.sv
// Shared definitions for avg_sub_calc: FSM state codes, widths and 7-segment glyphs.
// Segment bit order is bit0=a .. bit6=g, active-low (0 = segment lit).
package avg_sub_calc_pkg;

    localparam int STATE_W = 4;
    localparam int DATA_W  = 4;
    localparam int RES_W   = 5;
    localparam int SEG_W   = 7;

    typedef enum logic [STATE_W-1:0] {
        S_LOAD_A = 4'd0,
        S_LOAD_B = 4'd1,
        S_CALC   = 4'd2,
        S_SHOW   = 4'd3,
        S_HOLD   = 4'd4
    } state_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;

    function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] d);
        logic [SEG_W-1:0] g;
        case (d)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/avg_sub_calc_if.sv
// Operand bus, operation select and display/result outputs of avg_sub_calc.
interface avg_sub_calc_if;
    import avg_sub_calc_pkg::*;

    logic [DATA_W-1:0]  Dados;
    logic               Ins;
    logic [SEG_W-1:0]   Hex0;
    logic [SEG_W-1:0]   Hex1;
    logic [SEG_W-1:0]   Hex2;
    logic               fim;
    logic [STATE_W-1:0] state;
    logic [RES_W-1:0]   saidaC;

    modport master (
        output Dados, Ins,
        input  Hex0, Hex1, Hex2, fim, state, saidaC
    );

    modport slave (
        input  Dados, Ins,
        output Hex0, Hex1, Hex2, fim, state, saidaC
    );

endinterface

// File: rtl/avg_sub_calc_hex7seg.sv
// 4-bit to active-low 7-segment decoder; blank forces all segments off.
module avg_sub_calc_hex7seg
    import avg_sub_calc_pkg::*;
(
    input  logic [3:0]       digit,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : hex_glyph(digit);
    end

endmodule

// File: rtl/avg_sub_calc.sv
// Sequential 4-bit calculator: loads A then B, computes floor((A+B)/2) or (2A-B) mod 32.
// Build option SIGNED_DISPLAY_EN shows the 2A-B result as signed on the displays.
module avg_sub_calc
    import avg_sub_calc_pkg::*;
(
    input  logic           Clk,
    input  logic           Rst,
    avg_sub_calc_if.slave  bus
);

    state_t             state_reg;
    logic [DATA_W-1:0]  a_reg;
    logic [DATA_W-1:0]  b_reg;
    logic [RES_W-1:0]   saidac_reg;
    logic               fim_reg;
    logic [RES_W-1:0]   avg_res;
    logic [RES_W-1:0]   sub_res;
`ifdef SIGNED_DISPLAY_EN
    logic               op_reg;
`endif

    // Both results are formed at 5 bits so 2A-B wraps modulo 32.
    assign avg_res = RES_W'(({1'b0, a_reg} + {1'b0, b_reg}) >> 1);
    assign sub_res = {a_reg, 1'b0} - {1'b0, b_reg};

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_reg  <= S_LOAD_A;
            a_reg      <= '0;
            b_reg      <= '0;
            saidac_reg <= '0;
            fim_reg    <= 1'b0;
`ifdef SIGNED_DISPLAY_EN
            op_reg     <= 1'b0;
`endif
        end else begin
            fim_reg <= 1'b0;
            case (state_reg)
                S_LOAD_A: begin
                    a_reg     <= bus.Dados;
                    state_reg <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    b_reg     <= bus.Dados;
                    state_reg <= S_CALC;
                end
                S_CALC: begin
                    saidac_reg <= bus.Ins ? sub_res : avg_res;
                    fim_reg    <= 1'b1;
`ifdef SIGNED_DISPLAY_EN
                    op_reg     <= bus.Ins;
`endif
                    state_reg  <= S_SHOW;
                end
                S_SHOW:  state_reg <= S_HOLD;
                S_HOLD:  state_reg <= S_LOAD_A;
                default: state_reg <= S_LOAD_A;
            endcase
        end
    end

    assign bus.fim    = fim_reg;
    assign bus.state  = state_reg;
    assign bus.saidaC = saidac_reg;

    logic [RES_W-1:0] disp_val;
    logic             disp_neg;
    logic [1:0]       tens;
    logic [3:0]       ones;

`ifdef SIGNED_DISPLAY_EN
    assign disp_neg = op_reg & saidac_reg[RES_W-1];
    assign disp_val = disp_neg ? (RES_W'(0) - saidac_reg) : saidac_reg;
`else
    assign disp_neg = 1'b0;
    assign disp_val = saidac_reg;
`endif

    // Result is at most 31, so a three-step compare covers the decimal split.
    always_comb begin
        tens = 2'd0;
        ones = disp_val[3:0];
        if (disp_val >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(disp_val - 5'd30);
        end else if (disp_val >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(disp_val - 5'd20);
        end else if (disp_val >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(disp_val - 5'd10);
        end
    end

    logic [3:0]       dig [3];
    logic [2:0]       dig_blank;
    logic [SEG_W-1:0] seg [3];

    assign dig[0] = ones;
    assign dig[1] = {2'b00, tens};
    assign dig[2] = state_reg;
`ifdef SIGNED_DISPLAY_EN
    assign dig_blank = 3'b100;
`else
    assign dig_blank = 3'b000;
`endif

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_hex
            avg_sub_calc_hex7seg u_hex (
                .digit (dig[gi]),
                .blank (dig_blank[gi]),
                .seg   (seg[gi])
            );
        end
    endgenerate

    assign bus.Hex0 = seg[0];
    assign bus.Hex1 = seg[1];
    assign bus.Hex2 = disp_neg ? SEG_MINUS : seg[2];

endmodule

// File: tb/tb_avg_sub_calc.sv
// Directed scoreboard bench for avg_sub_calc: expected results are queued when operands are driven.
module tb_avg_sub_calc;

    logic Clk;
    logic Rst;

    avg_sub_calc_if bus ();

    avg_sub_calc dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0] val;
        logic       ins;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0:  return 7'h40;
            1:  return 7'h79;
            2:  return 7'h24;
            3:  return 7'h30;
            4:  return 7'h19;
            5:  return 7'h12;
            6:  return 7'h02;
            7:  return 7'h78;
            8:  return 7'h00;
            9:  return 7'h10;
            10: return 7'h08;
            11: return 7'h03;
            12: return 7'h46;
            13: return 7'h21;
            14: return 7'h06;
            15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_display(input exp_t e, input int st);
        int mag;
        logic [6:0] h2;
        mag = int'(e.val);
`ifdef SIGNED_DISPLAY_EN
        h2 = 7'h7F;
        if (e.ins && e.val >= 5'd16) begin
            mag = 32 - int'(e.val);
            h2  = 7'h3F;
        end
`else
        h2 = glyph(st);
`endif
        chk("hex0", bus.Hex0, glyph(mag % 10));
        chk("hex1", bus.Hex1, glyph(mag / 10));
        chk("hex2", bus.Hex2, h2);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic ins);
        exp_t e;
        int   r;
        int   wait_cnt;
        chk("state_load_a", bus.state, 0);
        bus.Dados = a;
        bus.Ins   = ins;
        if (ins) r = ((2 * int'(a) - int'(b)) % 32 + 32) % 32;
        else     r = (int'(a) + int'(b)) / 2;
        e.val = r[4:0];
        e.ins = ins;
        sb.push_back(e);
        @(negedge Clk);
        chk("fim_low_load_b", bus.fim, 0);
        chk("state_load_b", bus.state, 1);
        bus.Dados = b;
        wait_cnt = 0;
        do begin
            @(negedge Clk);
            wait_cnt++;
        end while (!bus.fim && wait_cnt < 8);
        chk("fim_latency", wait_cnt, 2);
        if (bus.fim) begin
            chk("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("saidac", bus.saidaC, e.val);
                chk("state_show", bus.state, 3);
                chk_display(e, 3);
                $display("op a=%0d b=%0d ins=%0d saidaC=%0d expected=%0d", a, b, ins, bus.saidaC, e.val);
            end
        end
        @(negedge Clk);
        chk("fim_one_cycle", bus.fim, 0);
        chk("saidac_hold", bus.saidaC, e.val);
        chk("state_hold", bus.state, 4);
`ifndef SIGNED_DISPLAY_EN
        chk("hex2_hold", bus.Hex2, glyph(4));
`endif
        @(negedge Clk);
    endtask

    initial begin
        exp_t z;
        checks    = 0;
        failures  = 0;
        Rst       = 1'b0;
        bus.Dados = 4'd0;
        bus.Ins   = 1'b0;
        z.val     = 5'd0;
        z.ins     = 1'b0;

        @(negedge Clk);
        chk("rst_state", bus.state, 0);
        chk("rst_saidac", bus.saidaC, 0);
        chk("rst_fim", bus.fim, 0);
        chk_display(z, 0);
        $display("reset state=%0d saidaC=%0d fim=%0d", bus.state, bus.saidaC, bus.fim);
        Rst = 1'b1;

        run_op(4'd15, 4'd15, 1'b0);
        run_op(4'd15, 4'd0,  1'b0);
        run_op(4'd0,  4'd15, 1'b1);

        for (int b = 15; b >= 0; b--) begin
            run_op(4'd15, 4'(b), 1'b1);
        end
        run_op(4'd15, 4'd1, 1'b0);

        // Abort a load in LOAD_B: everything clears and the next op starts from scratch.
        bus.Dados = 4'd5;
        @(negedge Clk);
        chk("mid_state_b", bus.state, 1);
        Rst = 1'b0;
        @(negedge Clk);
        chk("mid_rst_state", bus.state, 0);
        chk("mid_rst_saidac", bus.saidaC, 0);
        chk("mid_rst_fim", bus.fim, 0);
        $display("mid-op reset state=%0d saidaC=%0d", bus.state, bus.saidaC);
        Rst = 1'b1;
        run_op(4'd3, 4'd8, 1'b0);
        run_op(4'd9, 4'd4, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
